// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 slice datapath: operand widths and
// the OPMODE X/Z select encodings used by the post-adder stage.
// Latency: n/a (package). Backpressure: n/a.
package dsp48a1_pkg;

  localparam int P_W = 48;  // post-adder / P width
  localparam int M_W = 36;  // multiplier product width

  // X mux select, OPMODE[1:0]
  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  // Z mux select, OPMODE[3:2]
  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

endpackage

// File: rtl/dsp_reg_ce.sv
// Width-parameterised register with synchronous reset, clock enable and
// optional bypass. Latency: 1 cycle, or 0 when BYPASS=1. Backpressure: none (ce holds).
// Ports: clk, rst (sync, active-high, wins over ce), ce, d -> q (bypass-muxed), q_reg (always the flop).
module dsp_reg_ce #(
  parameter int W      = 48,
  parameter int BYPASS = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] q_reg
);

  always_ff @(posedge clk) begin
    if (rst)
      q_reg <= '0;
    else if (ce)
      q_reg <= d;
  end

  // The flop exists even in bypass mode so feedback users always see a registered value.
  assign q = (BYPASS != 0) ? d : q_reg;

endmodule

// File: rtl/dsp_post_adder.sv
// Post-adder/subtracter and P output register of the DSP48A1 slice.
// Latency: 1 cycle with PREG=1, 0 with PREG=0 (feedback always 1). Backpressure: none; CEP/CECARRYIN hold.
// Ports: CLK; RSTP/CEP and RSTCARRYIN/CECARRYIN for the P and carry
// registers; OPMODE, CIN, Cmux, M, DAB, PCIN operands; P/PCOUT and
// CARRYOUT/CARRYOUTF results. Macro DSP_CARRYOUT_EN enables the carry-out path;
// when undefined, CARRYOUT/CARRYOUTF are tied to 0.
module dsp_post_adder
  import dsp48a1_pkg::*;
#(
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic           CLK,
  input  logic           RSTP,
  input  logic           RSTCARRYIN,
  input  logic           CEP,
  input  logic           CECARRYIN,
  input  logic [7:0]     OPMODE,
  input  logic           CIN,
  input  logic [P_W-1:0] Cmux,
  input  logic [M_W-1:0] M,
  input  logic [P_W-1:0] DAB,
  input  logic [P_W-1:0] PCIN,
  output logic [P_W-1:0] P,
  output logic [P_W-1:0] PCOUT,
  output logic           CARRYOUT,
  output logic           CARRYOUTF
);

  logic [P_W-1:0] x_sel;
  logic [P_W-1:0] z_sel;
  logic [P_W-1:0] p_reg;
  logic [P_W:0]   x_cin;
  logic [P_W:0]   result;
  logic [P_W-1:0] sum;
  logic           co;

  // Feedback reads p_reg, never P, so PREG=0 cannot close a combinational loop.
  always_comb begin
    x_sel = '0;
    case (OPMODE[1:0])
      X_ZERO:  x_sel = '0;
      X_M:     x_sel = {{(P_W-M_W){1'b0}}, M};
      X_P:     x_sel = p_reg;
      X_DAB:   x_sel = DAB;
      default: x_sel = '0;
    endcase
  end

  always_comb begin
    z_sel = '0;
    case (OPMODE[3:2])
      Z_ZERO:  z_sel = '0;
      Z_PCIN:  z_sel = PCIN;
      Z_P:     z_sel = p_reg;
      Z_C:     z_sel = Cmux;
      default: z_sel = '0;
    endcase
  end

  // 49-bit arithmetic; bit 48 is carry on add and borrow on subtract.
  always_comb begin
    x_cin  = {1'b0, x_sel} + {{P_W{1'b0}}, CIN};
    result = OPMODE[7] ? ({1'b0, z_sel} - x_cin) : ({1'b0, z_sel} + x_cin);
  end

  assign sum = result[P_W-1:0];
  assign co  = result[P_W];

  dsp_reg_ce #(
    .W      (P_W),
    .BYPASS ((PREG == 0) ? 1 : 0)
  ) u_p_reg (
    .clk   (CLK),
    .rst   (RSTP),
    .ce    (CEP),
    .d     (sum),
    .q     (P),
    .q_reg (p_reg)
  );

  assign PCOUT = P;

`ifdef DSP_CARRYOUT_EN
  logic cy_q;
  logic cy_reg;

  dsp_reg_ce #(
    .W      (1),
    .BYPASS ((CARRYOUTREG == 0) ? 1 : 0)
  ) u_cy_reg (
    .clk   (CLK),
    .rst   (RSTCARRYIN),
    .ce    (CECARRYIN),
    .d     (co),
    .q     (cy_q),
    .q_reg (cy_reg)
  );

  assign CARRYOUT  = cy_q;
  assign CARRYOUTF = cy_q;

  // cy_reg is only consumed through q; OPMODE[6:4] carry no function here.
  logic unused_bits;
  assign unused_bits = ^{OPMODE[6:4], cy_reg};
`else
  assign CARRYOUT  = 1'b0;
  assign CARRYOUTF = 1'b0;

  // Carry path removed: its controls and the adder carry have no consumer.
  logic unused_bits;
  assign unused_bits = ^{OPMODE[6:4], RSTCARRYIN, CECARRYIN, co, CARRYOUTREG[0]};
`endif

endmodule
